// File: rtl/gt_refclk_rst_seq_pkg.sv
// gt_refclk_rst_seq_pkg: state encoding and default parameters for the GT refclk/reset sequencer
package gt_refclk_rst_seq_pkg;

    typedef enum logic [2:0] {
        REFCHK   = 3'd0,
        PLLRST   = 3'd1,
        PLLWAIT  = 3'd2,
        GTRST    = 3'd3,
        DONEWAIT = 3'd4,
        READY    = 3'd5,
        FAULT    = 3'd6
    } state_e;

    localparam int DEF_WINDOW        = 1024;
    localparam int DEF_EDGE_MIN      = 240;
    localparam int DEF_EDGE_MAX      = 272;
    localparam int DEF_PLLRST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_DONE_TIMEOUT  = 10000;
    localparam int DEF_MAX_RETRY     = 3;

endpackage

// File: rtl/gt_refclk_rst_seq_cdc_sync2.sv
// cdc_sync2: two-flop single-bit synchronizer into the i_clk domain
module cdc_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], i_d};
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/gt_refclk_rst_seq.sv
// gt_refclk_rst_seq: checks the GT refclk frequency, then sequences PLL and datapath resets with retries
module gt_refclk_rst_seq
    import gt_refclk_rst_seq_pkg::*;
#(
    parameter int WINDOW        = DEF_WINDOW,
    parameter int EDGE_MIN      = DEF_EDGE_MIN,
    parameter int EDGE_MAX      = DEF_EDGE_MAX,
    parameter int PLLRST_CYCLES = DEF_PLLRST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int DONE_TIMEOUT  = DEF_DONE_TIMEOUT,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_refclk_div,
    input  logic       i_pll_lock,
    input  logic       i_gt_rstdone,
    input  logic       i_restart,
    output logic       o_pll_reset,
    output logic       o_gt_reset,
    output logic       o_ready,
    output logic       o_fault,
    output logic [2:0] o_state,
    output logic [1:0] o_retry_cnt
);

    localparam int TMAX = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int WMAX = (WINDOW > PLLRST_CYCLES) ? WINDOW : PLLRST_CYCLES;
    localparam int WW   = $clog2(WMAX + 1);
    localparam int EW   = $clog2(WINDOW + 1);

    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [WW-1:0] RST_LAST  = WW'(PLLRST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);
    localparam logic [EW-1:0] E_MIN     = EW'(EDGE_MIN);
    localparam logic [EW-1:0] E_MAX     = EW'(EDGE_MAX);
    localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);

    state_e        state_q, state_d, tmo_st;
    logic [WW-1:0] win_q;
    logic [TW-1:0] tmr_q;
    logic [EW-1:0] edge_q, edge_d;
    logic [1:0]    retry_q, retry_inc;
    logic          ref_s, lock_s, done_s, ref_prev_q;
    logic          rise, edge_ok, tmo;

    cdc_sync2 u_sync_ref  (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_refclk_div), .o_q(ref_s));
    cdc_sync2 u_sync_lock (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_pll_lock),   .o_q(lock_s));
    cdc_sync2 u_sync_done (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_gt_rstdone), .o_q(done_s));

    assign rise      = ref_s & ~ref_prev_q;
    assign edge_d    = (rise && edge_q != '1) ? edge_q + 1'b1 : edge_q;
    assign edge_ok   = edge_q >= E_MIN && edge_q <= E_MAX;
    assign retry_inc = retry_q + 2'd1;
    assign tmo_st    = (retry_inc == RETRY_LIM) ? FAULT : PLLRST;
    assign tmo       = (state_q == PLLWAIT || state_q == DONEWAIT) && (state_d == PLLRST || state_d == FAULT);

    // success inputs are tested before the timeout so a same-cycle tie resolves as success
    always_comb begin
        state_d = state_q;
        case (state_q)
            REFCHK:   state_d = (win_q == WIN_LAST && edge_ok) ? PLLRST : REFCHK;
            PLLRST:   state_d = (win_q == RST_LAST) ? PLLWAIT : PLLRST;
            PLLWAIT:  state_d = lock_s ? GTRST : (tmr_q == LOCK_LAST) ? tmo_st : PLLWAIT;
            GTRST:    state_d = DONEWAIT;
            DONEWAIT: state_d = done_s ? READY : (!lock_s || tmr_q == DONE_LAST) ? tmo_st : DONEWAIT;
            READY:    state_d = (!lock_s || !done_s) ? PLLRST : i_restart ? REFCHK : READY;
            FAULT:    state_d = i_restart ? REFCHK : FAULT;
            default:  state_d = REFCHK;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= REFCHK;
            win_q      <= '0;
            tmr_q      <= '0;
            edge_q     <= '0;
            retry_q    <= '0;
            ref_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_prev_q <= ref_s;
            win_q      <= (state_d != state_q || win_q == WIN_LAST) ? '0 : win_q + 1'b1;
            tmr_q      <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
            edge_q     <= (state_q != REFCHK || win_q == WIN_LAST) ? '0 : edge_d;
            retry_q    <= tmo ? retry_inc : (state_d == READY || state_d == REFCHK) ? '0 : retry_q;
        end
    end

    assign o_state     = state_q;
    assign o_pll_reset = state_q inside {REFCHK, PLLRST, FAULT};
    assign o_gt_reset  = !(state_q inside {DONEWAIT, READY});
    assign o_ready     = state_q == READY;
    assign o_fault     = state_q == FAULT;
    assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_gt_refclk_rst_seq.sv
// tb_gt_refclk_rst_seq: scoreboard bench checking every state transition of the refclk/reset sequencer
module tb_gt_refclk_rst_seq;

    localparam logic [2:0] S_REF = 3'd0, S_PRST = 3'd1, S_PWAIT = 3'd2, S_GRST = 3'd3,
                           S_DWAIT = 3'd4, S_RDY = 3'd5, S_FLT = 3'd6;

    logic       clk = 1'b0, rst = 1'b1, refclk = 1'b0, lock = 1'b0, done = 1'b0, restart = 1'b0;
    logic       pll_rst, gt_rst, ready, fault;
    logic [2:0] st;
    logic [1:0] rc;
    int         errors = 0, checks = 0, ref_half = 2, ph = 0;

    typedef struct {
        string      nm;
        logic [2:0] st;
        logic [1:0] rc;
        int         dw;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ref_half != 0) begin
            ph = ph + 1;
            if (ph >= ref_half) begin
                ph = 0;
                refclk = ~refclk;
            end
        end
    end

    gt_refclk_rst_seq #(
        .WINDOW(64), .EDGE_MIN(14), .EDGE_MAX(18), .PLLRST_CYCLES(8),
        .LOCK_TIMEOUT(100), .DONE_TIMEOUT(50), .MAX_RETRY(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_refclk_div(refclk), .i_pll_lock(lock),
        .i_gt_rstdone(done), .i_restart(restart), .o_pll_reset(pll_rst),
        .o_gt_reset(gt_rst), .o_ready(ready), .o_fault(fault), .o_state(st),
        .o_retry_cnt(rc)
    );

    function automatic logic [8:0] pack(input logic [2:0] s, input logic [1:0] r);
        return {s, r, s == S_RDY, s == S_FLT, s == S_REF || s == S_PRST || s == S_FLT,
                !(s == S_DWAIT || s == S_RDY)};
    endfunction

    function automatic logic [8:0] obs();
        return {st, rc, ready, fault, pll_rst, gt_rst};
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic push(input string nm, input logic [2:0] s, input logic [1:0] r, input int d);
        exp_t e;
        e.nm = nm;
        e.st = s;
        e.rc = r;
        e.dw = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_st(input logic [2:0] s, input int budget, input string nm);
        int n;
        n = 0;
        while (st != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(st), int'(s));
    endtask

    task automatic mon();
        logic [2:0] prev;
        int         dwell;
        exp_t       e;
        prev  = S_REF;
        dwell = 0;
        forever begin
            @(negedge clk);
            if (st != prev) begin
                if (exp_q.size() == 0) chk("unexpected_transition", int'(st), int'(prev));
                else begin
                    e = exp_q.pop_front();
                    chk(e.nm, int'(obs()), int'(pack(e.st, e.rc)));
                    if (e.dw != 0) chk({e.nm, "_dwell"}, dwell, e.dw);
                end
                prev  = st;
                dwell = 1;
            end else dwell++;
        end
    endtask

    initial begin
        fork
            mon();
        join_none
        push("s1_pllrst", S_PRST, 2'd0, 0);
        push("s1_pllwait", S_PWAIT, 2'd0, 8);
        push("s1_gtrst", S_GRST, 2'd0, 23);
        push("s1_donewait", S_DWAIT, 2'd0, 1);
        push("s1_ready", S_RDY, 2'd0, 9);
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(obs()), int'(pack(S_REF, 2'd0)));
        rst = 1'b0;
        wait_st(S_PWAIT, 300, "s1_reach_pllwait");
        repeat (20) @(negedge clk);
        lock = 1'b1;
        repeat (10) @(negedge clk);
        done = 1'b1;
        wait_st(S_RDY, 100, "s1_reach_ready");
        chk("s1_ready_out", int'(ready), 1);
        chk("s1_retry", int'(rc), 0);

        push("s2_pllrst", S_PRST, 2'd0, 0);
        push("s2_pllwait", S_PWAIT, 2'd0, 8);
        push("s2_gtrst", S_GRST, 2'd0, 1);
        push("s2_donewait", S_DWAIT, 2'd0, 1);
        push("s2_ready", S_RDY, 2'd0, 1);
        repeat (5) @(negedge clk);
        lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("s2_ready_drop", int'(ready), 0);
        chk("s2_state_pllrst", int'(st), int'(S_PRST));
        repeat (2) @(negedge clk);
        lock = 1'b1;
        wait_st(S_RDY, 100, "s2_recover");

        push("s3_restart", S_REF, 2'd0, 0);
        push("s3_pllrst", S_PRST, 2'd0, 64);
        push("s3_pllwait1", S_PWAIT, 2'd0, 8);
        push("s3_timeout1", S_PRST, 2'd1, 100);
        push("s3_pllwait2", S_PWAIT, 2'd1, 8);
        push("s3_lock_at_100", S_GRST, 2'd1, 100);
        push("s3_donewait", S_DWAIT, 2'd1, 1);
        push("s3_rst_abort", S_REF, 2'd0, 4);
        restart = 1'b1;
        lock = 1'b0;
        done = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        wait_st(S_PWAIT, 200, "s3_reach_pllwait1");
        wait_st(S_PRST, 200, "s3_reach_timeout1");
        wait_st(S_PWAIT, 50, "s3_reach_pllwait2");
        repeat (97) @(negedge clk);
        lock = 1'b1;
        wait_st(S_DWAIT, 20, "s3_reach_donewait");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ref_half = 1;
        @(negedge clk);
        rst = 1'b0;
        chk("s3_reset_outputs", int'(obs()), int'(pack(S_REF, 2'd0)));

        repeat (300) @(negedge clk);
        chk("s4_stay_refchk", int'(st), int'(S_REF));
        chk("s4_pll_reset", int'(pll_rst), 1);
        chk("s4_retry", int'(rc), 0);
        chk("s4_no_pending", exp_q.size(), 0);

        push("s5_pllrst", S_PRST, 2'd0, 0);
        push("s5_pllwait1", S_PWAIT, 2'd0, 8);
        push("s5_timeout1", S_PRST, 2'd1, 100);
        push("s5_pllwait2", S_PWAIT, 2'd1, 8);
        push("s5_fault", S_FLT, 2'd2, 100);
        lock = 1'b0;
        ref_half = 2;
        wait_st(S_FLT, 800, "s5_reach_fault");
        chk("s5_fault_out", int'(fault), 1);
        chk("s5_retry", int'(rc), 2);
        chk("s5_resets_held", int'({pll_rst, gt_rst}), 3);
        push("s5_restart", S_REF, 2'd0, 0);
        ref_half = 0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        chk("s5_fault_clear", int'(fault), 0);
        chk("s5_state_refchk", int'(st), int'(S_REF));
        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
